// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet controller.
//   state_t   : controller FSM states
//   ERR_*     : error codes reported on o_error
//   strobe_t  : datapath control strobe bundle
//   strobes_for() : Moore strobe decode for a state
package maxnet_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        LOAD = 4'd1,
        CLR  = 4'd2,
        STRT = 4'd3,
        WAIT = 4'd4,
        CHK  = 4'd5,
        UPD  = 4'd6,
        FIN  = 4'd7,
        DONE = 4'd8,
        ERR  = 4'd9
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_ITER = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    typedef struct packed {
        logic rst_plu;
        logic eps_reg_we;
        logic we_a_reg;
        logic we_prim;
        logic mux_sel;
        logic start;
    } strobe_t;

    // Strobe pattern driven while the FSM sits in state s.
    function automatic strobe_t strobes_for(input state_t s);
        strobe_t st;
        st = '0;
        case (s)
            LOAD: begin
                st.eps_reg_we = 1'b1;
                st.we_a_reg   = 1'b1;
                st.we_prim    = 1'b1;
                st.mux_sel    = 1'b1;
            end
            CLR:  st.rst_plu  = 1'b1;
            STRT: st.start    = 1'b1;
            UPD:  st.we_a_reg = 1'b1;
            default: st = '0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/maxnet_watchdog.sv
// Loadable up-counter bounding the wait for plu_done / finish.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : load i_load_val (wins over i_en)
//   i_load_val     : value loaded on i_load
//   i_en           : count one cycle (saturating)
//   o_expired_c    : combinational; high while enabled on the cycle whose
//                    increment makes the count reach LIMIT
module maxnet_watchdog #(
    parameter int unsigned LIMIT = 255,
    parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired_c
);

    logic [CNT_W-1:0] r_count;

    // Counter register; saturates instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired_c = i_en && (r_count >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/maxnet_controller.sv
// Sequencer for the four-neuron Maxnet datapath: load, iterate until the
// PLU outputs stop changing, then wait for the output check.
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_go             : start request (IDLE only)
//   i_abort          : abort the current run with ERR_TMO
//   i_plu_done, i_loop, i_overflow, i_finish : datapath status
//   o_rst_plu, o_eps_reg_we, o_we_a_reg, o_we_prim, o_mux_sel, o_start :
//                      registered datapath strobes
//   o_busy           : not IDLE
//   o_done           : one-cycle end-of-run pulse (DONE or ERR)
//   o_error          : result code, held until the next go
//   o_iter_count     : completed update iterations (saturating)
// ITER_W must satisfy 2**ITER_W > MAX_ITER.
module maxnet_controller
    import maxnet_pkg::*;
#(
    parameter int unsigned MAX_ITER    = 64,
    parameter int unsigned ITER_W      = 8,
    parameter int unsigned PLU_TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_go,
    input  logic              i_abort,
    input  logic              i_plu_done,
    input  logic              i_loop,
    input  logic              i_overflow,
    input  logic              i_finish,
    output logic              o_rst_plu,
    output logic              o_eps_reg_we,
    output logic              o_we_a_reg,
    output logic              o_we_prim,
    output logic              o_mux_sel,
    output logic              o_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_error,
    output logic [ITER_W-1:0] o_iter_count
);

    localparam int unsigned WD_W = $clog2(PLU_TIMEOUT + 1);

    state_t             r_state,  w_state_nxt;
    strobe_t            r_strb,   w_strb_nxt;
    logic               r_busy,   w_busy_nxt;
    logic               r_done,   w_done_nxt;
    logic [1:0]         r_error,  w_error_nxt;
    logic [ITER_W-1:0]  r_iter,   w_iter_nxt;

    logic               w_wd_load;
    logic [WD_W-1:0]    w_wd_load_val;
    logic               w_wd_en;
    logic               w_wd_expired;

    maxnet_watchdog #(
        .LIMIT (PLU_TIMEOUT),
        .CNT_W (WD_W)
    ) u_watchdog (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_wd_load),
        .i_load_val  (w_wd_load_val),
        .i_en        (w_wd_en),
        .o_expired_c (w_wd_expired)
    );

    // State and registered Moore outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_strb  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= ERR_NONE;
            r_iter  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_strb  <= w_strb_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_error <= w_error_nxt;
            r_iter  <= w_iter_nxt;
        end
    end

    // Next state, counters and watchdog control.
    always_comb begin
        w_state_nxt   = r_state;
        w_error_nxt   = r_error;
        w_iter_nxt    = r_iter;
        w_wd_load     = 1'b0;
        w_wd_load_val = '0;
        w_wd_en       = 1'b0;

        case (r_state)
            IDLE: begin
                w_wd_load = 1'b1;
                if (i_go) begin
                    w_state_nxt = LOAD;
                    w_error_nxt = ERR_NONE;
                    w_iter_nxt  = '0;
                end
            end
            LOAD: w_state_nxt = CLR;
            CLR:  w_state_nxt = STRT;
            STRT: begin
                // The start cycle itself counts toward the PLU timeout.
                w_wd_load     = 1'b1;
                w_wd_load_val = WD_W'(1);
                w_state_nxt   = WAIT;
            end
            WAIT: begin
                w_wd_en = 1'b1;
                if (i_plu_done) begin
                    w_state_nxt = CHK;
                end else if (w_wd_expired) begin
                    w_state_nxt = ERR;
                    w_error_nxt = ERR_TMO;
                end
            end
            CHK: begin
                // Restart the watchdog so FIN gets a fresh budget.
                w_wd_load = 1'b1;
                if (i_overflow) begin
                    w_state_nxt = ERR;
                    w_error_nxt = ERR_OVF;
                end else if (i_loop) begin
                    w_state_nxt = FIN;
                end else if (r_iter == ITER_W'(MAX_ITER)) begin
                    w_state_nxt = ERR;
                    w_error_nxt = ERR_ITER;
                end else begin
                    w_state_nxt = UPD;
                end
            end
            UPD: begin
                if (r_iter != {ITER_W{1'b1}}) begin
                    w_iter_nxt = r_iter + ITER_W'(1);
                end
                w_state_nxt = CLR;
            end
            FIN: begin
                w_wd_en = 1'b1;
                if (i_finish) begin
                    w_state_nxt = DONE;
                end else if (w_wd_expired) begin
                    w_state_nxt = ERR;
                    w_error_nxt = ERR_TMO;
                end
            end
            DONE:    w_state_nxt = IDLE;
            ERR:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // Abort overrides everything; an aborted UPD does not count.
        // ERR is already reporting, so it always returns to IDLE.
        if (i_abort && (r_state != IDLE) && (r_state != ERR)) begin
            w_state_nxt = ERR;
            w_error_nxt = ERR_TMO;
            w_iter_nxt  = r_iter;
        end
    end

    // Output decode from the next state, so outputs align with r_state.
    always_comb begin
        w_strb_nxt = strobes_for(w_state_nxt);
        w_busy_nxt = (w_state_nxt != IDLE);
        w_done_nxt = (w_state_nxt == DONE) || (w_state_nxt == ERR);
    end

    assign o_rst_plu    = r_strb.rst_plu;
    assign o_eps_reg_we = r_strb.eps_reg_we;
    assign o_we_a_reg   = r_strb.we_a_reg;
    assign o_we_prim    = r_strb.we_prim;
    assign o_mux_sel    = r_strb.mux_sel;
    assign o_start      = r_strb.start;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_iter_count = r_iter;

endmodule

// File: tb/tb_maxnet_controller.sv
// Self-checking bench for maxnet_controller with a behavioural PLU stub.
module tb_maxnet_controller;

    localparam int unsigned MAX_ITER    = 4;
    localparam int unsigned ITER_W      = 8;
    localparam int unsigned PLU_TIMEOUT = 10;
    localparam int          PLU_DELAY   = 5;
    localparam int          FIN_DELAY   = 2;

    logic              clk = 1'b0;
    logic              i_rst_n;
    logic              i_go, i_abort, i_plu_done, i_loop, i_overflow, i_finish;
    logic              o_rst_plu, o_eps_reg_we, o_we_a_reg, o_we_prim, o_mux_sel, o_start;
    logic              o_busy, o_done;
    logic [1:0]        o_error;
    logic [ITER_W-1:0] o_iter_count;

    always #5 clk = ~clk;

    maxnet_controller #(
        .MAX_ITER    (MAX_ITER),
        .ITER_W      (ITER_W),
        .PLU_TIMEOUT (PLU_TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_go         (i_go),
        .i_abort      (i_abort),
        .i_plu_done   (i_plu_done),
        .i_loop       (i_loop),
        .i_overflow   (i_overflow),
        .i_finish     (i_finish),
        .o_rst_plu    (o_rst_plu),
        .o_eps_reg_we (o_eps_reg_we),
        .o_we_a_reg   (o_we_a_reg),
        .o_we_prim    (o_we_prim),
        .o_mux_sel    (o_mux_sel),
        .o_start      (o_start),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_iter_count (o_iter_count)
    );

    typedef struct {
        logic [8*8-1:0] name;
        int             loop_at;      // CHK index where loop=1 (-1: never)
        int             ovf_at;       // CHK index where overflow=1 (-1: never)
        bit             plu_never;
        bit             go_in_wait;
        bit             abort_in_upd;
        bit             chk_fin_lat;
        bit             chk_tmo_lat;
        int             exp_starts;
        int             exp_upds;
        int             exp_iter;
        logic [1:0]     exp_err;
    } vec_t;

    typedef struct {
        int         starts;
        int         upds;
        int         iter;
        logic [1:0] err;
    } res_t;

    vec_t vecs[6];
    res_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, req);
        end
    endtask

    function automatic int all_outs();
        return int'({o_rst_plu, o_eps_reg_we, o_we_a_reg, o_we_prim, o_mux_sel,
                     o_start, o_busy, o_done, o_error, o_iter_count});
    endfunction

    task automatic run_vec(input vec_t v);
        string vn;
        res_t  e, got;
        int    starts = 0, upds = 0, loads = 0, chk_idx = 0;
        int    plu_cnt = -1, fin_cnt = -1;
        int    first_start = -1, last_start = -1, fin_cyc = -1, done_cyc = -1;
        vn = $sformatf("%0s", v.name);
        got = '{0, 0, 0, 2'b00};

        @(negedge clk);
        i_loop = 1'b0; i_overflow = 1'b0;
        i_go = 1'b1;
        e = '{v.exp_starts, v.exp_upds, v.exp_iter, v.exp_err};
        sb.push_back(e);

        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            i_go = 1'b0; i_plu_done = 1'b0; i_finish = 1'b0; i_abort = 1'b0;
            if (o_done) begin
                done_cyc = cyc;
                got = '{starts, upds, int'(o_iter_count), o_error};
                break;
            end
            if (o_eps_reg_we) loads++;
            if (o_we_a_reg && !o_mux_sel) begin
                upds++;
                if (v.abort_in_upd) i_abort = 1'b1;
            end
            if (fin_cnt > 0) begin
                fin_cnt--;
                if (fin_cnt == 0) begin
                    i_finish = 1'b1;
                    fin_cyc  = cyc;
                end
            end
            if (o_start) begin
                starts++;
                if (first_start < 0) first_start = cyc;
                last_start = cyc;
                plu_cnt = v.plu_never ? -1 : PLU_DELAY;
            end else if (plu_cnt > 0) begin
                plu_cnt--;
                if (v.go_in_wait && plu_cnt == 3) i_go = 1'b1;
                if (plu_cnt == 0) begin
                    i_plu_done = 1'b1;
                    i_loop     = (chk_idx == v.loop_at);
                    i_overflow = (chk_idx == v.ovf_at);
                    if (chk_idx == v.loop_at) fin_cnt = FIN_DELAY;
                    chk_idx++;
                end
            end
        end
        i_go = 1'b0; i_plu_done = 1'b0; i_finish = 1'b0; i_abort = 1'b0;
        i_loop = 1'b0; i_overflow = 1'b0;

        if (done_cyc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s done_wait: got no done, expected done within 300 cycles", vn);
        end
        e = sb.pop_front();
        check({vn, " starts"}, got.starts, e.starts);
        check({vn, " upd_cycles"}, got.upds, e.upds);
        check({vn, " iter_count"}, got.iter, e.iter);
        check({vn, " error"}, int'(got.err), int'(e.err));
        check({vn, " go_to_start"}, first_start, 3);
        check({vn, " load_cycles"}, loads, 1);
        if (v.chk_fin_lat) check({vn, " finish_to_done"}, done_cyc - fin_cyc, 1);
        if (v.chk_tmo_lat) check({vn, " start_to_err"}, done_cyc - last_start, int'(PLU_TIMEOUT));

        @(negedge clk);
        check({vn, " busy_after"}, int'(o_busy), 0);
        check({vn, " done_after"}, int'(o_done), 0);
        check({vn, " error_held"}, int'(o_error), int'(e.err));
        check({vn, " iter_held"}, int'(o_iter_count), e.iter);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_go = 1'b0; i_abort = 1'b0; i_plu_done = 1'b0;
        i_loop = 1'b0; i_overflow = 1'b0; i_finish = 1'b0;

        //           name       loop ovf never gow abrt finL tmoL st upd it err
        vecs[0] = '{"conv",      0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 2'b00};
        vecs[1] = '{"iter3",     3, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 3, 3, 2'b00};
        vecs[2] = '{"ovf",      -1,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1, 1, 2'b01};
        vecs[3] = '{"limit",    -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 4, 4, 2'b10};
        vecs[4] = '{"timeout",  -1, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 2'b11};
        vecs[5] = '{"abort",    -1, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 0, 2'b11};

        // Reset state while reset is held.
        #12;
        check("reset_outputs", all_outs(), 0);
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(o_busy), 0);
        check("idle_outputs", all_outs(), 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Asynchronous reset in the middle of WAIT.
        @(negedge clk);
        i_go = 1'b1;
        @(negedge clk);
        i_go = 1'b0;
        for (int k = 0; k < 20 && !o_start; k++) @(negedge clk);
        check("arst start_seen", int'(o_start), 1);
        @(negedge clk);
        check("arst busy_in_wait", int'(o_busy), 1);
        #2 i_rst_n = 1'b0;
        #1 check("arst outputs_zero", all_outs(), 0);
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("arst stays_idle", all_outs(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/maxnet_controller.md
Name: maxnet_controller

Overview:
- FSM sequencing the four-neuron Maxnet datapath through load, iterate-until-stable, and result collection.
- Drives the datapath control strobes: rst_plu, eps_reg_we, we_a_reg, we_prim, mux_sel and start.
- Consumes the datapath status flags: plu_done, loop, overflow and finish.
- Adds a top-level go/done handshake, an iteration limit, a PLU watchdog and error reporting.
- Sits between the system top and the datapath as the datapath's only controller.

Parameters:
- MAX_ITER, 64: iteration limit; exceeding it aborts with error code 2'b10.
- ITER_W, 8: width of iter_count; must satisfy 2^ITER_W > MAX_ITER.
- PLU_TIMEOUT, 255: maximum cycles spent waiting for plu_done before error code 2'b11.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- go  in  1  start request; sampled only in IDLE.
- abort  in  1  synchronous abort; honoured in every non-IDLE state.
- plu_done  in  1  all four PLUs complete.
- loop  in  1  1 = every PLU output equals its a-register (converged).
- overflow  in  1  OR of the PLU overflow flags.
- finish  in  1  output-check valid.
- rst_plu  out  1  PLU reset pulse, active-high.
- eps_reg_we  out  1  epsilon register write enable.
- we_a_reg  out  1  a-register write enable.
- we_prim  out  1  prime-register write enable.
- mux_sel  out  1  1 = a-registers load a*_init; 0 = a-registers load PLU outputs.
- start  out  1  PLU start pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  2  00 ok, 01 overflow, 10 iteration limit, 11 PLU timeout/abort; held until the next go.
- iter_count  out  ITER_W  number of completed update iterations.

Behaviour:
Reset (rst=0, asynchronous):
- State goes to IDLE.
- All outputs 0, except error=00 and iter_count=0.
- Reset mid-operation abandons the run immediately; datapath strobes drop in the same instant.

States:
- IDLE:
  - Strobes 0.
  - On go=1: clear error, iter_count and watchdog, then go to LOAD.
- LOAD, 1 cycle:
  - Drive eps_reg_we=1, we_a_reg=1, we_prim=1, mux_sel=1.
  - Next state: CLR.
- CLR, 1 cycle:
  - Drive rst_plu=1.
  - Next state: STRT.
- STRT, 1 cycle:
  - Drive start=1.
  - Clear the watchdog.
  - Next state: WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - plu_done=1 -> CHK.
  - Watchdog reaches PLU_TIMEOUT -> ERR with code 11.
  - plu_done wins if both occur in the same cycle.
- CHK, 1 cycle, priority order:
  - overflow=1 -> ERR, code 01.
  - loop=1 -> FIN.
  - iter_count == MAX_ITER -> ERR, code 10.
  - Otherwise -> UPD.
- UPD, 1 cycle:
  - Drive we_a_reg=1, mux_sel=0.
  - iter_count += 1.
  - Next state: CLR.
- FIN:
  - Wait for finish=1, then go to DONE.
  - Bounded by the same watchdog, which is cleared on entry; timeout -> ERR, code 11.
- DONE, 1 cycle:
  - done=1, then IDLE.
- ERR, 1 cycle:
  - done=1 with error latched, then IDLE.

Strobes and counters:
- All strobes are registered Moore outputs, one cycle wide; nothing is combinationally derived from inputs.
- abort=1 in any non-IDLE state -> ERR with code 11; abort has priority over every other transition.
- go while busy is ignored; go held high re-triggers only after IDLE is re-entered.
- iter_count saturates at its maximum and never wraps; it holds its final value after done until the next go.
- Latency:
  - go to first start: 3 cycles (LOAD, CLR, STRT).
  - Each extra iteration: CHK + UPD + CLR + STRT = 4 cycles plus the PLU time.

Decomposition:
- Shared package maxnet_pkg holds:
  - the state enum (IDLE, LOAD, CLR, STRT, WAIT, CHK, UPD, FIN, DONE, ERR);
  - error-code constants ERR_NONE, ERR_OVF, ERR_ITER, ERR_TMO.
- One sub-module, maxnet_watchdog: a loadable counter with clear/enable and an expired flag, sized for PLU_TIMEOUT.

Test Plan:
- Immediate convergence:
  - Stimulus: go; stub returns plu_done 5 cycles after start, loop=1, then finish 2 cycles later.
  - Required: one start pulse, done one cycle after finish, iter_count=0, error=00.
- Three iterations:
  - Stimulus: loop=0,0,0,1 on successive CHKs.
  - Required: four start pulses, three UPD cycles with we_a_reg=1/mux_sel=0, iter_count=3, error=00.
- Overflow:
  - Stimulus: overflow=1 at the second CHK.
  - Required: error=01, done pulse, iter_count=1, no further start.
- Iteration limit:
  - Stimulus: MAX_ITER=4, loop never 1.
  - Required: error=10 after iter_count=4; exactly 5 start pulses.
- Timeout:
  - Stimulus: PLU_TIMEOUT=10, plu_done never asserted.
  - Required: ERR reached 10 cycles after start, error=11.
  - Then pulse rst low mid-WAIT: all outputs 0 asynchronously.
- go while busy, and abort:
  - Stimulus: go pulsed during WAIT is ignored; abort in UPD.
  - Required: error=11, busy falls the cycle after the done pulse.
